// File: rtl/div_if.sv
// Ex-stage <-> divider handshake: operands and start/cancel from Ex,
// registered result and status back from the divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             cancel_i;
    logic             signed_i;
    logic [WIDTH-1:0] opdata1_i;
    logic [WIDTH-1:0] opdata2_i;
    logic [WIDTH-1:0] quot_o;
    logic [WIDTH-1:0] rem_o;
    logic             ready_o;
    logic             busy_o;
    logic             dbz_o;

    modport master (
        output start_i, cancel_i, signed_i, opdata1_i, opdata2_i,
        input  quot_o, rem_o, ready_o, busy_o, dbz_o
    );

    modport slave (
        input  start_i, cancel_i, signed_i, opdata1_i, opdata2_i,
        output quot_o, rem_o, ready_o, busy_o, dbz_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 integer divider (signed/unsigned) for the Ex stage,
// one quotient bit per cycle, with optional trivial-case fast path and divide-by-zero report.
module div_unit #(
    parameter int               WIDTH     = 32,
    parameter bit               FAST_PATH = 1'b0,
    parameter logic [WIDTH-1:0] DBZ_QUOT  = {WIDTH{1'b1}}
) (
    input logic  clk,
    input logic  rst,
    div_if.slave div_bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DBZ, S_FIX, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic             r_sgn_q, r_sgn_r;
    logic [WIDTH-1:0] r_quot_o, r_rem_o;
    logic             r_ready, r_busy, r_dbz;

    logic [WIDTH-1:0] w_a1, w_a2;
    logic             w_accept, w_op2_zero, w_neg1, w_neg2;
    logic [WIDTH:0]   w_part, w_diff;

    function automatic logic [WIDTH-1:0] f_neg(input logic signed [WIDTH-1:0] v);
        return -v;
    endfunction

    assign w_neg1     = div_bus.signed_i & div_bus.opdata1_i[WIDTH-1];
    assign w_neg2     = div_bus.signed_i & div_bus.opdata2_i[WIDTH-1];
    assign w_a1       = w_neg1 ? f_neg(div_bus.opdata1_i) : div_bus.opdata1_i;
    assign w_a2       = w_neg2 ? f_neg(div_bus.opdata2_i) : div_bus.opdata2_i;
    assign w_accept   = div_bus.start_i & ~div_bus.cancel_i;
    assign w_op2_zero = (div_bus.opdata2_i == '0);

    // Trial subtract in WIDTH+1 bits; MSB set means the divisor did not fit.
    assign w_part = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff = w_part - {1'b0, r_dvs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_op2_zero)                  w_next = S_DBZ;
                    else if (FAST_PATH && (w_a1 < w_a2)) w_next = S_FIX;
                    else                             w_next = S_RUN;
                end
            end
            S_RUN:  if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
            S_DBZ:  w_next = S_DONE;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (!div_bus.start_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (div_bus.cancel_i && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_sgn_q  <= 1'b0;
            r_sgn_r  <= 1'b0;
            r_quot_o <= '0;
            r_rem_o  <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_busy  <= (w_next == S_RUN) || (w_next == S_DBZ) || (w_next == S_FIX);
            r_ready <= (w_next == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sgn_q <= w_neg1 ^ w_neg2;
                        r_sgn_r <= w_neg1;
                        r_dvs   <= w_a2;
                        r_cnt   <= '0;
                        if (w_op2_zero) begin
                            r_rem <= div_bus.opdata1_i;
                            r_dvd <= '0;
                        end else if (w_next == S_FIX) begin
                            r_rem <= w_a1;
                            r_dvd <= '0;
                        end else begin
                            r_rem <= '0;
                            r_dvd <= w_a1;
                        end
                    end
                end
                S_RUN: begin
                    // Dividend register doubles as the quotient shift register.
                    r_dvd <= {r_dvd[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_rem <= w_diff[WIDTH] ? w_part[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase

            if (w_next == S_IDLE) begin
                r_quot_o <= '0;
                r_rem_o  <= '0;
                r_dbz    <= 1'b0;
            end else if ((r_state == S_FIX) && (w_next == S_DONE)) begin
                r_quot_o <= r_sgn_q ? f_neg(r_dvd) : r_dvd;
                r_rem_o  <= r_sgn_r ? f_neg(r_rem) : r_rem;
            end else if ((r_state == S_DBZ) && (w_next == S_DONE)) begin
                r_quot_o <= DBZ_QUOT;
                r_rem_o  <= r_rem;
                r_dbz    <= 1'b1;
            end
        end
    end

    assign div_bus.quot_o  = r_quot_o;
    assign div_bus.rem_o   = r_rem_o;
    assign div_bus.ready_o = r_ready;
    assign div_bus.busy_o  = r_busy;
    assign div_bus.dbz_o   = r_dbz;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: one instance without and one with the fast path.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) if0 ();
  div_if #(.WIDTH(32)) if1 ();

  div_unit #(.WIDTH(32), .FAST_PATH(1'b0)) dut    (.clk(clk), .rst(rst), .div_bus(if0));
  div_unit #(.WIDTH(32), .FAST_PATH(1'b1)) dut_fp (.clk(clk), .rst(rst), .div_bus(if1));

  bit sel = 1'b0;
  logic [31:0] m_quot, m_rem;
  logic m_ready, m_busy, m_dbz;
  assign m_quot  = sel ? if1.quot_o  : if0.quot_o;
  assign m_rem   = sel ? if1.rem_o   : if0.rem_o;
  assign m_ready = sel ? if1.ready_o : if0.ready_o;
  assign m_busy  = sel ? if1.busy_o  : if0.busy_o;
  assign m_dbz   = sel ? if1.dbz_o   : if0.dbz_o;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    bit          dbz;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit fp, input logic st, input logic cn, input logic sg,
                       input logic [31:0] a, input logic [31:0] b);
    if (fp) begin
      if1.start_i = st; if1.cancel_i = cn; if1.signed_i = sg;
      if1.opdata1_i = a; if1.opdata2_i = b;
    end else begin
      if0.start_i = st; if0.cancel_i = cn; if0.signed_i = sg;
      if0.opdata1_i = a; if0.opdata2_i = b;
    end
  endtask

  function automatic exp_t model(input bit fp, input bit sg, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa, sb;
    logic [31:0] ma, mb;
    sa = a; sb = b;
    ma = (sg && sa < 0) ? -a : a;
    mb = (sg && sb < 0) ? -b : b;
    e.dbz = 1'b0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.lat = 2;
      return e;
    end
    if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000; e.r = 32'd0;
      end else begin
        e.q = sa / sb; e.r = sa % sb;
      end
    end else begin
      e.q = a / b; e.r = a % b;
    end
    e.lat = (fp && ma < mb) ? 2 : 34;
    return e;
  endfunction

  task automatic do_op(input bit fp, input bit sg, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    exp_t p;
    int cyc, nbusy;
    sb_q.push_back(model(fp, sg, a, b));
    sel = fp;
    @(negedge clk);
    drive(fp, 1'b1, 1'b0, sg, a, b);
    cyc = 0; nbusy = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) drive(fp, 1'b1, 1'b0, sg, $urandom, $urandom);
      if (m_busy) nbusy++;
    end while (!m_ready && cyc < 100);
    p = sb_q.pop_front();
    chk("latency", 64'(cyc), 64'(p.lat));
    chk("busy_cycles", 64'(nbusy), 64'(p.lat - 1));
    chk("quot", 64'(m_quot), 64'(p.q));
    chk("rem", 64'(m_rem), 64'(p.r));
    chk("dbz", 64'(m_dbz), 64'(p.dbz));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_ready", 64'(m_ready), 64'd1);
      chk("hold_quot", 64'(m_quot), 64'(p.q));
      chk("hold_rem", 64'(m_rem), 64'(p.r));
      chk("hold_dbz", 64'(m_dbz), 64'(p.dbz));
    end
    @(negedge clk);
    drive(fp, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("clr_ready", 64'(m_ready), 64'd0);
    chk("clr_quot", 64'(m_quot), 64'd0);
    chk("clr_rem", 64'(m_rem), 64'd0);
    chk("clr_dbz", 64'(m_dbz), 64'd0);
    chk("clr_busy", 64'(m_busy), 64'd0);
  endtask

  initial begin
    bit rose;
    logic [31:0] ra, rb;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      chk("rst_ready", 64'(m_ready), 64'd0);
      chk("rst_busy", 64'(m_busy), 64'd0);
      chk("rst_quot", 64'(m_quot), 64'd0);
      chk("rst_rem", 64'(m_rem), 64'd0);
      chk("rst_dbz", 64'(m_dbz), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic cases on the plain instance.
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 0);
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(1'b0, 1'b0, 32'd5, 32'd0, 3);
    do_op(1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0, 1);
    do_op(1'b0, 1'b0, 32'd3, 32'd10, 0);
    do_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);

    // Fast-path instance: trivial and non-trivial operands.
    do_op(1'b1, 1'b0, 32'd3, 32'd10, 0);
    do_op(1'b1, 1'b0, 32'd0, 32'd5, 1);
    do_op(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd10, 0);
    do_op(1'b1, 1'b0, 32'd100, 32'd7, 0);
    do_op(1'b1, 1'b0, 32'd9, 32'd0, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      do_op(1'b0, i[0], ra, rb, 0);
    end

    // Cancel during RUN iteration 10, then an immediate new operation.
    sel = 1'b0;
    rose = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    repeat (10) begin
      @(posedge clk); #1;
      rose |= m_ready;
    end
    chk("cancel_busy_before", 64'(m_busy), 64'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
    @(posedge clk); #1;
    chk("cancel_busy", 64'(m_busy), 64'd0);
    chk("cancel_quot", 64'(m_quot), 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
      rose |= m_ready;
    end
    chk("cancel_no_ready", 64'(rose), 64'd0);
    do_op(1'b0, 1'b0, 32'd9, 32'd3, 0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 64'(m_busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(m_busy), 64'd0);
    chk("arst_ready", 64'(m_ready), 64'd0);
    chk("arst_quot", 64'(m_quot), 64'd0);
    chk("arst_rem", 64'(m_rem), 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(m_ready), 64'd0);
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
